scan_mux: RTL

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/scan_mux.sv
// scan_mux: seven-segment digit scanner, 1 dark GAP cycle + DWELL lit cycles per digit; SCAN_MUX_LEADING_ZERO_EN adds leading-zero blanking.
// Outputs are registered from the next state. There is no backpressure: the scanner free-runs while en=1.
module scan_mux #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 4
) (
    input  logic                  clk_1khz,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DIGITS*4-1:0]   digit_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     scan,
    output logic [7:0]            seg_code,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [7:0]    LAST_CNT = 8'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

    state_t                r_state, w_nxt_state;
    logic [IW-1:0]         r_idx, w_nxt_idx;
    logic [7:0]            r_cnt, w_nxt_cnt;
    logic                  w_frame_end;
    logic                  w_snap;

    logic [DIGITS*4-1:0]   r_snap_data;
    logic [DIGITS-1:0]     r_snap_dp;
    logic [DIGITS-1:0]     r_snap_blank;
    logic [DIGITS-1:0]     w_snap_blank;

    logic [DIGITS-1:0]     r_scan, w_onehot;
    logic [7:0]            r_seg, w_seg;
    logic [3:0]            w_digit;
    logic                  r_frame_done;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        case (v)
            4'h0: f_decode = 7'h3F;
            4'h1: f_decode = 7'h06;
            4'h2: f_decode = 7'h5B;
            4'h3: f_decode = 7'h4F;
            4'h4: f_decode = 7'h66;
            4'h5: f_decode = 7'h6D;
            4'h6: f_decode = 7'h7D;
            4'h7: f_decode = 7'h07;
            4'h8: f_decode = 7'h7F;
            4'h9: f_decode = 7'h6F;
            4'hA: f_decode = 7'h77;
            4'hB: f_decode = 7'h7C;
            4'hC: f_decode = 7'h39;
            4'hD: f_decode = 7'h5E;
            4'hE: f_decode = 7'h79;
            default: f_decode = 7'h71;
        endcase
    endfunction

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt;
        w_frame_end = 1'b0;
        w_snap      = 1'b0;
        if (!en) begin
            w_nxt_state = IDLE;
            w_nxt_idx   = '0;
            w_nxt_cnt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nxt_state = GAP;
                    w_nxt_idx   = '0;
                    w_nxt_cnt   = '0;
                    w_snap      = 1'b1;
                end
                GAP: begin
                    w_nxt_state = SHOW;
                    w_nxt_cnt   = '0;
                end
                SHOW: begin
                    if (r_cnt == LAST_CNT) begin
                        w_nxt_state = GAP;
                        w_nxt_cnt   = '0;
                        if (r_idx == LAST_IDX) begin
                            w_nxt_idx   = '0;
                            w_frame_end = 1'b1;
                            w_snap      = 1'b1;
                        end else begin
                            w_nxt_idx = r_idx + 1'b1;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_nxt_state = IDLE;
                    w_nxt_idx   = '0;
                    w_nxt_cnt   = '0;
                end
            endcase
        end
    end

`ifdef SCAN_MUX_LEADING_ZERO_EN
    logic [DIGITS-1:0] w_lz_mask;
    logic              w_lead;

    // Walk down from the top digit; the first nonzero value or lit dp ends the run.
    always_comb begin
        w_lz_mask = '0;
        w_lead    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_lead && (digit_data[4*i +: 4] == 4'h0) && !dp_in[i]) begin
                w_lz_mask[i] = 1'b1;
            end else begin
                w_lead = 1'b0;
            end
        end
        w_snap_blank = blank | w_lz_mask;
    end
`else
    assign w_snap_blank = blank;
`endif

    // Output decode looks at the upcoming slot so the registered outputs line up with r_state.
    always_comb begin
        w_onehot            = '0;
        w_onehot[w_nxt_idx] = 1'b1;
        w_digit             = r_snap_data[{w_nxt_idx, 2'b00} +: 4];
        w_seg               = '0;
        if (!r_snap_blank[w_nxt_idx]) begin
            w_seg = {r_snap_dp[w_nxt_idx], f_decode(w_digit)};
        end
    end

    always_ff @(posedge clk_1khz or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_snap_data  <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
            r_scan       <= '0;
            r_seg        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_cnt        <= w_nxt_cnt;
            r_frame_done <= w_frame_end;
            if (w_snap) begin
                r_snap_data  <= digit_data;
                r_snap_dp    <= dp_in;
                r_snap_blank <= w_snap_blank;
            end
            if (w_nxt_state == SHOW) begin
                r_scan <= w_onehot;
                r_seg  <= w_seg;
            end else begin
                r_scan <= '0;
                r_seg  <= '0;
            end
        end
    end

    assign scan       = r_scan;
    assign seg_code   = r_seg;
    assign frame_done = r_frame_done;

endmodule
